// File: rtl/stream_demux_if.sv
// stream_demux_if: producer-side and consumer-side handshake bundle for stream_demux
interface stream_demux_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = ($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH)
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic [SEL_W-1:0]  in_sel;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;
  modport master (
    output in_data, in_valid, in_last, in_sel, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );
  modport slave (
    input  in_data, in_valid, in_last, in_sel, out_ready,
    output in_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-NUM_CH valid/ready demux with optional packet route locking and drop counting
module stream_demux #(
  parameter int DATA_W   = 8,
  parameter int NUM_CH   = 8,
  parameter int SEL_W    = ($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH),
  parameter int PKT_MODE = 1
) (
  input  logic               clk,
  input  logic               rst,
  stream_demux_if.slave      bus,
  output logic [15:0]        drop_cnt,
  output logic               busy
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t            state_q, state_d;
  logic              full_q, full_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [SEL_W-1:0]  lock_q, lock_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]  eff_sel;
  logic              sel_ok;
  logic              fire;
  logic              acc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      full_q  <= 1'b0;
      ch_q    <= '0;
      lock_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      ch_q    <= ch_d;
      lock_q  <= lock_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = (PKT_MODE == 0 || !acc) ? state_q : (bus.in_last ? IDLE : LOCKED);
    lock_d  = (PKT_MODE != 0 && acc && state_q == IDLE && !bus.in_last) ? bus.in_sel : lock_q;
    full_d  = (acc && sel_ok) ? 1'b1 : (fire ? 1'b0 : full_q);
    ch_d    = (acc && sel_ok) ? eff_sel : ch_q;
    data_d  = (acc && sel_ok) ? bus.in_data : data_q;
    last_d  = (acc && sel_ok) ? bus.in_last : last_q;
    cnt_d   = (acc && !sel_ok && cnt_q != '1) ? cnt_q + 16'd1 : cnt_q;
  end
  always_comb begin
    eff_sel       = (PKT_MODE != 0 && state_q == LOCKED) ? lock_q : bus.in_sel;
    sel_ok        = 32'(eff_sel) < NUM_CH;
    bus.out_valid = full_q ? (NUM_CH'(1) << ch_q) : '0;
    bus.out_data  = data_q;
    bus.out_last  = last_q;
    fire          = |(bus.out_valid & bus.out_ready);
    bus.in_ready  = !sel_ok || !full_q || fire;
    acc           = bus.in_valid && bus.in_ready;
    busy          = state_q == LOCKED || full_q;
    drop_cnt      = cnt_q;
  end
endmodule
